// File: rtl/position_history_recorder.sv
// Triggered history buffer for beam position samples (X, Y, Q, S).
// Records pre-trigger history, then a programmed post-trigger count, then freezes for readout.
module position_history_recorder #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gpioData,
  input  logic                  csrStrobe,
  input  logic                  trigger,
  input  logic                  posToggle,
  input  logic [DATA_WIDTH-1:0] posX,
  input  logic [DATA_WIDTH-1:0] posY,
  input  logic [DATA_WIDTH-1:0] posQ,
  input  logic [DATA_WIDTH-1:0] posS,
  input  logic [ADDR_WIDTH+1:0] readAddr,
  output logic [DATA_WIDTH-1:0] readData,
  output logic [DATA_WIDTH-1:0] csr,
  output logic                  done
);

  localparam int DEPTH         = 2 ** ADDR_WIDTH;
  localparam int ARM_BIT       = 31;
  localparam int SOFT_TRIG_BIT = 30;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   write_ptr_q, write_ptr_d;
  logic [ADDR_WIDTH-1:0]   post_remain_q, post_remain_d;
  logic [ADDR_WIDTH-1:0]   post_count_q, post_count_d;
  logic [ADDR_WIDTH-1:0]   trigger_addr_q, trigger_addr_d;
  logic                    wrapped_q, wrapped_d;
  logic                    pos_toggle_q;
  logic                    trigger_q;
  logic [DATA_WIDTH-1:0]   read_data_q, read_data_d;

  logic [3:0][DATA_WIDTH-1:0] ram [DEPTH];

  logic                    sample_evt;
  logic                    trig_evt;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   read_idx;
  logic [1:0]              read_lane;
  logic                    unused_gpio;

  assign sample_evt  = posToggle != pos_toggle_q;
  assign trig_evt    = trigger & ~trigger_q;
  assign read_idx    = readAddr[ADDR_WIDTH+1:2];
  assign read_lane   = readAddr[1:0];
  assign unused_gpio = ^gpioData[SOFT_TRIG_BIT-1:ADDR_WIDTH];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    write_ptr_d    = write_ptr_q;
    post_remain_d  = post_remain_q;
    post_count_d   = post_count_q;
    trigger_addr_d = trigger_addr_q;
    wrapped_d      = wrapped_q;
    wr_en          = 1'b0;

    if (csrStrobe) begin
      if (gpioData[ARM_BIT]) begin
        write_ptr_d  = '0;
        wrapped_d    = 1'b0;
        post_count_d = gpioData[ADDR_WIDTH-1:0];
        if (gpioData[SOFT_TRIG_BIT]) begin
          // Soft trigger lands on the fresh arm: the next sample is the first post sample.
          state_d        = POST;
          trigger_addr_d = '0;
          post_remain_d  = gpioData[ADDR_WIDTH-1:0];
        end else begin
          state_d = ARMED;
        end
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        ARMED: begin
          if (sample_evt) begin
            wr_en       = 1'b1;
            write_ptr_d = write_ptr_q + 1'b1;
            if (write_ptr_q == PTR_MAX) wrapped_d = 1'b1;
          end
          if (trig_evt) begin
            trigger_addr_d = write_ptr_q;
            if (!sample_evt) begin
              post_remain_d = post_count_q;
              state_d       = POST;
            end else if (post_count_q == '0) begin
              state_d = DONE;
            end else begin
              post_remain_d = post_count_q - 1'b1;
              state_d       = POST;
            end
          end
        end
        POST: begin
          if (sample_evt) begin
            wr_en       = 1'b1;
            write_ptr_d = write_ptr_q + 1'b1;
            if (write_ptr_q == PTR_MAX) wrapped_d = 1'b1;
            if (post_remain_q == '0) state_d = DONE;
            else                     post_remain_d = post_remain_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    read_data_d = ram[read_idx][read_lane];
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      write_ptr_q    <= '0;
      post_remain_q  <= '0;
      post_count_q   <= '0;
      trigger_addr_q <= '0;
      wrapped_q      <= 1'b0;
      pos_toggle_q   <= 1'b0;
      trigger_q      <= 1'b0;
      read_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      write_ptr_q    <= write_ptr_d;
      post_remain_q  <= post_remain_d;
      post_count_q   <= post_count_d;
      trigger_addr_q <= trigger_addr_d;
      wrapped_q      <= wrapped_d;
      pos_toggle_q   <= posToggle;
      trigger_q      <= trigger;
      read_data_q    <= read_data_d;
    end
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) ram[write_ptr_q] <= {posS, posQ, posY, posX};
  end

  assign readData = read_data_q;
  assign csr      = DATA_WIDTH'({state_q, wrapped_q, 13'b0, trigger_addr_q});
  assign done     = state_q == DONE;

endmodule
